// File: rtl/gf_pkg.sv
// GF(2^8) constants and arithmetic shared by the RS decoder stages.
// Root-bank seed values are computed here at elaboration time.
package gf_pkg;

  localparam int SYMB_WIDTH      = 8;
  localparam int N_LEN           = 255;
  localparam int T_LEN           = 8;
  localparam int ROOTS_PER_CYCLE = 4;

  localparam int GF_ORDER = (1 << SYMB_WIDTH) - 1;
  localparam int NC =
    (N_LEN + ROOTS_PER_CYCLE - 1) / ROOTS_PER_CYCLE;
  localparam int CYC_W   = (NC > 1) ? $clog2(NC) : 1;
  localparam int POS_W   = $clog2(NC * ROOTS_PER_CYCLE + 1);
  localparam int CNT_W   = $clog2(T_LEN + 2);
  localparam int NUM_W   = $clog2(T_LEN + 1);
  localparam int LIST_IW = (T_LEN > 1) ? $clog2(T_LEN) : 1;

  typedef logic [SYMB_WIDTH-1:0] sym_t;
  typedef logic [ROOTS_PER_CYCLE-1:0][SYMB_WIDTH-1:0] root_vec_t;

  // x^8 + x^4 + x^3 + x^2 + 1, low byte only
  localparam sym_t PRIM_LOW = 8'h1D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DONE
  } state_t;

  function automatic sym_t gf_mult(input sym_t a, input sym_t b);
    sym_t p;
    sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) p = p ^ x;
      if (x[SYMB_WIDTH-1])
        x = {x[SYMB_WIDTH-2:0], 1'b0} ^ PRIM_LOW;
      else
        x = {x[SYMB_WIDTH-2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic sym_t gf_alpha_pow(input int e);
    sym_t r;
    r = sym_t'(1);
    for (int i = 0; i < GF_ORDER; i++)
      if (i < e) r = gf_mult(r, sym_t'(2));
    return r;
  endfunction

  function automatic root_vec_t root_init();
    root_vec_t v;
    for (int i = 0; i < ROOTS_PER_CYCLE; i++)
      v[i] = gf_alpha_pow((GF_ORDER - (i % GF_ORDER)) % GF_ORDER);
    return v;
  endfunction

  localparam root_vec_t ROOT_INIT = root_init();
  localparam sym_t ALPHA_NEG_R = gf_alpha_pow(
    (GF_ORDER - (ROOTS_PER_CYCLE % GF_ORDER)) % GF_ORDER);

endpackage

// File: rtl/rs_chien.sv
// Parallel evaluation of the error locator at R roots.
// Bit R-1-i of error_bit_pos flags a zero on lane i.
module rs_chien
  import gf_pkg::*;
(
  input  logic [T_LEN:0][SYMB_WIDTH-1:0]           error_locator,
  input  logic [ROOTS_PER_CYCLE-1:0][SYMB_WIDTH-1:0] roots,
  output logic [ROOTS_PER_CYCLE-1:0]               error_bit_pos
);

  always_comb begin
    sym_t v_acc;
    v_acc         = '0;
    error_bit_pos = '0;
    for (int i = 0; i < ROOTS_PER_CYCLE; i++) begin
      v_acc = '0;
      // Horner from the top coefficient down
      for (int k = T_LEN; k >= 0; k--)
        v_acc = gf_mult(v_acc, roots[i]) ^ error_locator[k];
      error_bit_pos[ROOTS_PER_CYCLE-1-i] = (v_acc == '0);
    end
  end

endmodule

// File: rtl/rs_chien_pos.sv
// Sequential Chien search: sweeps all positions R per clock and
// compacts the roots into an ascending error-position list.
module rs_chien_pos
  import gf_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             err_loc_vld,
  output logic                             err_loc_rdy,
  input  logic [T_LEN:0][SYMB_WIDTH-1:0]   error_locator,
  output logic                             err_pos_vld,
  output logic [T_LEN-1:0][SYMB_WIDTH-1:0] err_pos,
  output logic [NUM_W-1:0]                 err_pos_num,
  output logic                             decode_fail
);

  state_t                           r_state;
  state_t                           w_next;
  logic [CYC_W-1:0]                 r_cyc;
  root_vec_t                        r_roots;
  logic [T_LEN:0][SYMB_WIDTH-1:0]   r_loc;
  logic [CNT_W-1:0]                 r_deg;
  logic [CNT_W-1:0]                 r_cnt;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] r_list;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] r_err_pos;
  logic [NUM_W-1:0]                 r_err_num;
  logic                             r_fail;

  logic [ROOTS_PER_CYCLE-1:0]       w_bits;
  logic [ROOTS_PER_CYCLE-1:0]       w_hit;
  logic [ROOTS_PER_CYCLE-1:0][POS_W-1:0] w_idx;
  logic [CNT_W-1:0]                 w_cnt_nxt;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] w_list_nxt;
  logic [CNT_W-1:0]                 w_deg;
  logic                             w_accept;
  logic                             w_last;

  rs_chien u_chien (
    .error_locator (r_loc),
    .roots         (r_roots),
    .error_bit_pos (w_bits)
  );

  assign w_accept    = (r_state == ST_IDLE) && err_loc_vld;
  assign w_last      = (r_cyc == CYC_W'(NC - 1));
  assign err_loc_rdy = (r_state == ST_IDLE);
  assign err_pos_vld = (r_state == ST_DONE);
  assign err_pos     = r_err_pos;
  assign err_pos_num = r_err_num;
  assign decode_fail = r_fail;

  always_comb begin
    w_deg = '0;
    for (int k = 0; k <= T_LEN; k++)
      if (error_locator[k] != '0) w_deg = CNT_W'(k);
  end

  // Un-reverse lane order and mask the tail of the last cycle
  always_comb begin
    w_idx = '0;
    w_hit = '0;
    for (int i = 0; i < ROOTS_PER_CYCLE; i++) begin
      w_idx[i] = POS_W'(r_cyc) * POS_W'(ROOTS_PER_CYCLE)
               + POS_W'(i);
      w_hit[i] = w_bits[ROOTS_PER_CYCLE-1-i]
               && (w_idx[i] < POS_W'(N_LEN));
    end
  end

  always_comb begin
    logic [CNT_W-1:0] v_cnt;
    v_cnt      = r_cnt;
    w_list_nxt = r_list;
    for (int i = 0; i < ROOTS_PER_CYCLE; i++) begin
      if (w_hit[i]) begin
        if (v_cnt < CNT_W'(T_LEN))
          w_list_nxt[v_cnt[LIST_IW-1:0]] =
            w_idx[i][SYMB_WIDTH-1:0];
        if (v_cnt <= CNT_W'(T_LEN))
          v_cnt = v_cnt + 1'b1;
      end
    end
    w_cnt_nxt = v_cnt;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (err_loc_vld) w_next = ST_SEARCH;
      ST_SEARCH: if (w_last) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cyc     <= '0;
      r_roots   <= '0;
      r_loc     <= '0;
      r_deg     <= '0;
      r_cnt     <= '0;
      r_list    <= '0;
      r_err_pos <= '0;
      r_err_num <= '0;
      r_fail    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_loc   <= error_locator;
        r_deg   <= w_deg;
        r_roots <= ROOT_INIT;
        r_cnt   <= '0;
        r_list  <= '0;
        r_cyc   <= '0;
      end else if (r_state == ST_SEARCH) begin
        for (int i = 0; i < ROOTS_PER_CYCLE; i++)
          r_roots[i] <= gf_mult(r_roots[i], ALPHA_NEG_R);
        r_cnt  <= w_cnt_nxt;
        r_list <= w_list_nxt;
        r_cyc  <= r_cyc + 1'b1;
        if (w_last) begin
          r_err_pos <= w_list_nxt;
          r_err_num <= (w_cnt_nxt > CNT_W'(T_LEN))
                     ? NUM_W'(T_LEN)
                     : w_cnt_nxt[NUM_W-1:0];
          r_fail    <= (w_cnt_nxt != r_deg)
                    || (w_cnt_nxt > CNT_W'(T_LEN));
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_chien_pos.sv
// Self-checking bench for rs_chien_pos against a table-based
// GF(256) reference that evaluates the locator at every position.
module tb_rs_chien_pos;
  import gf_pkg::*;

  typedef logic [T_LEN:0][SYMB_WIDTH-1:0]   lam_t;
  typedef logic [T_LEN-1:0][SYMB_WIDTH-1:0] pos_t;

  logic             clk;
  logic             rst_n;
  logic             err_loc_vld;
  logic             err_loc_rdy;
  lam_t             error_locator;
  logic             err_pos_vld;
  pos_t             err_pos;
  logic [NUM_W-1:0] err_pos_num;
  logic             decode_fail;

  int n_checks;
  int n_fail;
  int exp_t[0:509];
  int log_t[0:255];

  rs_chien_pos dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .err_loc_vld   (err_loc_vld),
    .err_loc_rdy   (err_loc_rdy),
    .error_locator (error_locator),
    .err_pos_vld   (err_pos_vld),
    .err_pos       (err_pos),
    .err_pos_num   (err_pos_num),
    .decode_fail   (decode_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic init_gf();
    int v;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i]       = v;
      exp_t[i + 255] = v;
      log_t[v]       = i;
      v = v << 1;
      if (v & 256) v = v ^ 'h11D;
    end
    exp_t[510 - 1] = exp_t[254];
    log_t[0] = 0;
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[log_t[a] + log_t[b]];
  endfunction

  function automatic int eval_at(input lam_t lam, input int j);
    int x;
    int acc;
    x   = exp_t[(255 - j) % 255];
    acc = 0;
    for (int k = T_LEN; k >= 0; k--)
      acc = gmul(acc, x) ^ int'(lam[k]);
    return acc;
  endfunction

  function automatic lam_t poly_from(input int q[$]);
    lam_t r;
    int   a;
    r    = '0;
    r[0] = 8'd1;
    foreach (q[n]) begin
      a = exp_t[q[n]];
      for (int k = T_LEN; k >= 1; k--)
        r[k] = r[k] ^ 8'(gmul(a, int'(r[k-1])));
    end
    return r;
  endfunction

  function automatic int root_count(input lam_t lam);
    int c;
    c = 0;
    for (int j = 0; j < N_LEN; j++)
      if (eval_at(lam, j) == 0) c++;
    return c;
  endfunction

  function automatic void model(input lam_t lam,
                                output pos_t epos,
                                output int enm,
                                output bit efail);
    int cnt;
    int deg;
    epos = '0;
    cnt  = 0;
    for (int j = 0; j < N_LEN; j++) begin
      if (eval_at(lam, j) == 0) begin
        if (cnt < T_LEN) epos[cnt] = 8'(j);
        cnt++;
      end
    end
    deg = 0;
    for (int k = 0; k <= T_LEN; k++)
      if (lam[k] != 0) deg = k;
    enm   = (cnt > T_LEN) ? T_LEN : cnt;
    efail = (cnt != deg) || (cnt > T_LEN);
  endfunction

  task automatic run_one(input lam_t lam, input string nm,
                         output pos_t opos, output int onum,
                         output bit ofail);
    pos_t epos;
    int   enm;
    bit   efail;
    int   lat;
    model(lam, epos, enm, efail);
    opos  = '0;
    onum  = 0;
    ofail = 1'b0;
    lat   = -1;
    @(negedge clk);
    n_checks++;
    if (err_loc_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s rdy: got %b want 1", nm, err_loc_rdy);
    end
    error_locator = lam;
    err_loc_vld   = 1'b1;
    for (int t = 1; t <= 200 && lat < 0; t++) begin
      @(negedge clk);
      err_loc_vld = 1'b0;
      if (err_pos_vld === 1'b1) lat = t;
    end
    n_checks++;
    if (lat != NC + 1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d",
               nm, lat, NC + 1);
    end
    if (lat < 0) return;
    opos  = err_pos;
    onum  = int'(err_pos_num);
    ofail = decode_fail;
    n_checks++;
    if (onum != enm) begin
      n_fail++;
      $display("FAIL %s num: got %0d want %0d", nm, onum, enm);
    end
    n_checks++;
    if (ofail !== efail) begin
      n_fail++;
      $display("FAIL %s fail: got %b want %b", nm, ofail, efail);
    end
    n_checks++;
    if (opos !== epos) begin
      n_fail++;
      $display("FAIL %s pos: got %h want %h", nm, opos, epos);
    end
    @(negedge clk);
    n_checks++;
    if (err_pos_vld !== 1'b0 || err_pos !== epos) begin
      n_fail++;
      $display("FAIL %s hold: vld %b pos %h want 0 %h",
               nm, err_pos_vld, err_pos, epos);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (err_loc_rdy !== 1'b1 || err_pos_vld !== 1'b0 ||
        err_pos !== '0 || err_pos_num !== '0 ||
        decode_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: rdy %b vld %b pos %h num %0d fail %b",
               err_loc_rdy, err_pos_vld, err_pos,
               err_pos_num, decode_fail);
    end
  endtask

  task automatic test_deg0();
    pos_t p; int n; bit f; lam_t l; int q[$];
    q = {};
    l = poly_from(q);
    run_one(l, "deg0", p, n, f);
    n_checks++;
    if (n != 0 || f !== 1'b0 || p !== '0) begin
      n_fail++;
      $display("FAIL deg0 const: num %0d fail %b pos %h", n, f, p);
    end
  endtask

  task automatic test_single();
    pos_t p; int n; bit f; int q[$];
    q = {10};
    run_one(poly_from(q), "single", p, n, f);
    n_checks++;
    if (n != 1 || f !== 1'b0 || p[0] !== 8'd10) begin
      n_fail++;
      $display("FAIL single const: num %0d fail %b pos0 %0d",
               n, f, p[0]);
    end
  endtask

  task automatic test_boundary();
    pos_t p; int n; bit f; int q[$];
    q = {254, 4, 0, 3};
    run_one(poly_from(q), "boundary", p, n, f);
    n_checks++;
    if (n != 4 || f !== 1'b0 || p[0] !== 8'd0 ||
        p[1] !== 8'd3 || p[2] !== 8'd4 || p[3] !== 8'd254) begin
      n_fail++;
      $display("FAIL boundary const: num %0d fail %b pos %h",
               n, f, p);
    end
  endtask

  task automatic test_deg3_one_root();
    pos_t p; int n; bit f; lam_t quad; lam_t l; int q[$];
    int tries;
    quad  = '0;
    tries = 0;
    do begin
      quad    = '0;
      quad[0] = 8'd1;
      quad[1] = 8'd1;
      quad[2] = 8'($urandom_range(1, 255));
      tries++;
    end while (root_count(quad) != 0 && tries < 300);
    q = {7};
    l = poly_from(q);
    // (1 + a^7 x) * quad, degree 3
    l = '0;
    l[0] = quad[0];
    l[1] = quad[1] ^ 8'(gmul(exp_t[7], int'(quad[0])));
    l[2] = quad[2] ^ 8'(gmul(exp_t[7], int'(quad[1])));
    l[3] = 8'(gmul(exp_t[7], int'(quad[2])));
    run_one(l, "deg3", p, n, f);
    n_checks++;
    if (n != 1 || f !== 1'b1 || p[0] !== 8'd7) begin
      n_fail++;
      $display("FAIL deg3 const: num %0d fail %b pos0 %0d",
               n, f, p[0]);
    end
  endtask

  task automatic test_zero_lambda();
    pos_t p; int n; bit f;
    run_one('0, "zero", p, n, f);
    n_checks++;
    if (n != T_LEN || f !== 1'b1 || p[T_LEN-1] !== 8'(T_LEN - 1))
    begin
      n_fail++;
      $display("FAIL zero const: num %0d fail %b pos %h", n, f, p);
    end
  endtask

  task automatic test_random();
    pos_t p; int n; bit f; lam_t l; int q[$]; bit used[255];
    int nr; int j; int dg;
    for (int it = 0; it < 12; it++) begin
      if (it % 4 == 3) begin
        l  = '0;
        dg = $urandom_range(1, T_LEN);
        for (int k = 0; k <= dg; k++)
          l[k] = 8'($urandom_range(0, 255));
      end else begin
        q  = {};
        foreach (used[u]) used[u] = 1'b0;
        nr = $urandom_range(0, T_LEN);
        while (q.size() < nr) begin
          j = $urandom_range(0, N_LEN - 1);
          if (!used[j]) begin
            used[j] = 1'b1;
            q.push_back(j);
          end
        end
        l = poly_from(q);
      end
      run_one(l, $sformatf("rand%0d", it), p, n, f);
    end
  endtask

  task automatic test_back_to_back();
    lam_t la; lam_t lb; int qa[$]; int qb[$];
    int acc[$]; pos_t res[$]; int rn[$];
    pos_t ep; int en; bit ef;
    int want_acc[3];
    qa = {5};
    qb = {20, 200};
    la = poly_from(qa);
    lb = poly_from(qb);
    want_acc = '{0, 2 * (NC + 2) / 2, 2 * (NC + 2)};
    for (int t = 0; t <= 3 * (NC + 2); t++) begin
      @(negedge clk);
      err_loc_vld   = (t <= 2 * (NC + 2));
      error_locator = (t == 0) ? la : lb;
      if (err_loc_rdy && err_loc_vld) acc.push_back(t);
      if (err_pos_vld === 1'b1) begin
        res.push_back(err_pos);
        rn.push_back(int'(err_pos_num));
      end
    end
    err_loc_vld = 1'b0;
    n_checks++;
    if (acc.size() != 3) begin
      n_fail++;
      $display("FAIL b2b accepts: got %0d want 3", acc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (acc[i] != want_acc[i]) begin
          n_fail++;
          $display("FAIL b2b accept%0d: got %0d want %0d",
                   i, acc[i], want_acc[i]);
        end
      end
    end
    n_checks++;
    if (res.size() != 3) begin
      n_fail++;
      $display("FAIL b2b results: got %0d want 3", res.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        model((i == 0) ? la : lb, ep, en, ef);
        n_checks++;
        if (res[i] !== ep || rn[i] != en) begin
          n_fail++;
          $display("FAIL b2b res%0d: got %h/%0d want %h/%0d",
                   i, res[i], rn[i], ep, en);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    pos_t p; int n; bit f; int q[$]; int seen;
    q = {33};
    @(negedge clk);
    error_locator = poly_from(q);
    err_loc_vld   = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      err_loc_vld = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (err_pos_vld !== 1'b0 || err_pos !== '0 ||
        err_pos_num !== '0 || decode_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid clear: vld %b pos %h num %0d fail %b",
               err_pos_vld, err_pos, err_pos_num, decode_fail);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (err_pos_vld === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0 || err_loc_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid idle: vld seen %0d rdy %b want 0 1",
               seen, err_loc_rdy);
    end
    q = {100};
    run_one(poly_from(q), "rst_fresh", p, n, f);
    n_checks++;
    if (n != 1 || p[0] !== 8'd100) begin
      n_fail++;
      $display("FAIL rst_fresh const: num %0d pos0 %0d want 1 100",
               n, p[0]);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    err_loc_vld   = 1'b0;
    error_locator = '0;
    init_gf();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_deg0();
    test_single();
    test_boundary();
    test_deg3_one_root();
    test_zero_lambda();
    test_random();
    repeat (2) @(negedge clk);
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
